// File: rtl/booth_mul_sched_pkg.sv
// Shared types, default sizes and width helpers for the Booth multiplier scheduler.
package booth_sched_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned X_DEF       = 4;
  localparam int unsigned Y_DEF       = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Bits needed to index v items (or count 0..v-1); never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/booth_mul_sched_if.sv
// Requester bus plus multiplier-core bus seen by the scheduler.
interface booth_sched_if
  import booth_sched_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned X = X_DEF,
  parameter int unsigned Y = Y_DEF
);

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*(X+1)-1:0] req_m;
  logic [N*Y-1:0]     req_r;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [X+Y-1:0]     rsp_p;
  logic               rsp_err;
  logic               mul_start;
  logic [X:0]         mul_m;
  logic [Y-1:0]       mul_r;
  logic               mul_done;
  logic [X+Y-1:0]     mul_p;

  // Requesters and the multiplier core together form the master side.
  modport master (
    output req_valid, req_m, req_r, rsp_ready, mul_done, mul_p,
    input  req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_r
  );

  // The scheduler is the slave side.
  modport slave (
    input  req_valid, req_m, req_r, rsp_ready, mul_done, mul_p,
    output req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_r
  );

endinterface

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest index at or above ptr (mod N) wins.
module rr_arbiter
  import booth_sched_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   idx,
  output logic                  any
);

  localparam int unsigned IW = clog2(N);

  logic [IW-1:0] k;

  // Scan requesters starting at ptr; first valid one takes the grant.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IW'((32'(ptr) + i) % N);
      if (!any && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one sequential Booth multiplier among N requesters, round-robin,
// with a timeout guard on the core's done pulse.
module booth_mul_sched
  import booth_sched_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned X       = X_DEF,
  parameter int unsigned Y       = Y_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  booth_sched_if.slave       bus,
  output logic               busy
);

  localparam int unsigned MW = X + 1;
  localparam int unsigned IW = clog2(N);
  localparam int unsigned CW = clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] g_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_any;

  logic [MW-1:0] m_arr [N];
  logic [Y-1:0]  r_arr [N];

  logic          accept_c;
  logic          done_c;
  logic          tmo_c;
  logic          finish_c;

  rr_arbiter #(.N(N)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Unpack per-requester operand slices.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      m_arr[i] = bus.req_m[i*MW +: MW];
      r_arr[i] = bus.req_r[i*Y +: Y];
    end
  end

  // Only the granted requester sees ready, and only while idle and out of reset.
  assign bus.req_ready = (state_q == IDLE && !rst) ? arb_gnt : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle event strobes; done beats a coincident timeout.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    done_c   = 1'b0;
    tmo_c    = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          accept_c = 1'b1;
          state_d  = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.mul_done) begin
          done_c  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_c   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[g_q]) begin
          finish_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, timeout counter, response and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      g_q           <= '0;
      cnt_q         <= '0;
      busy          <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_m     <= '0;
      bus.mul_r     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_p     <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.mul_start <= accept_c;
      busy          <= (state_d != IDLE);

      if (accept_c) begin
        g_q       <= arb_idx;
        bus.mul_m <= m_arr[arb_idx];
        bus.mul_r <= r_arr[arb_idx];
      end

      if (state_q == START)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);

      if (done_c) begin
        bus.rsp_p     <= bus.mul_p;
        bus.rsp_err   <= 1'b0;
        bus.rsp_valid <= N'(1) << g_q;
      end else if (tmo_c) begin
        bus.rsp_p     <= '0;
        bus.rsp_err   <= 1'b1;
        bus.rsp_valid <= N'(1) << g_q;
      end

      if (finish_c) begin
        bus.rsp_valid <= '0;
        ptr_q         <= (g_q == IW'(N - 1)) ? '0 : g_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched with a behavioural multiplier core.
module tb_booth_mul_sched;
  import booth_sched_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned X       = 4;
  localparam int unsigned Y       = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned MW      = X + 1;
  localparam int unsigned PW      = X + Y;

  typedef struct {
    int            idx;
    logic [PW-1:0] p;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  booth_sched_if #(.N(N), .X(X), .Y(Y)) bus ();

  booth_mul_sched #(.N(N), .X(X), .Y(Y), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic signed [X:0]   m_op [N];
  logic signed [Y-1:0] r_op [N];

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      bus.req_m[i*MW +: MW] = m_op[i];
      bus.req_r[i*Y +: Y]   = r_op[i];
    end
  end

  exp_t          sb [$];
  int            order [$];
  int            n_checks = 0;
  int            n_err    = 0;
  int            cyc      = 0;
  int            core_lat;        // 0: never done, <0: random 1..5
  bit            core_pend;
  int            core_cnt;
  logic [PW-1:0] core_prod;
  logic [N-1:0]  oneshot;
  logic [N-1:0]  drop;
  logic [N-1:0]  prev_rsp_valid;
  int            last_acc_cyc;
  int            last_rsp_lat;
  int            rdy0_cnt;
  logic [PW-1:0] last_rsp_p;
  logic          last_rsp_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] exp_prod(input logic signed [X:0] m, input logic signed [Y-1:0] r);
    int p;
    p = int'(m) * int'(r);
    return PW'(p);
  endfunction

  // One clock: monitor at negedge, then drive requesters/core just after posedge.
  task automatic tick();
    exp_t e;
    int   gi;
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        e.idx = i;
        e.err = (core_lat == 0);
        e.p   = e.err ? '0 : exp_prod(m_op[i], r_op[i]);
        sb.push_back(e);
        order.push_back(i);
        last_acc_cyc = cyc;
        if (oneshot[i]) drop[i] = 1'b1;
      end
    end
    if (bus.req_ready[0]) rdy0_cnt++;
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    if (bus.rsp_valid != '0) begin
      if (prev_rsp_valid == '0) last_rsp_lat = cyc - last_acc_cyc;
      check("rsp_onehot", 32'($countones(bus.rsp_valid)), 1);
      gi = 0;
      for (int i = int'(N) - 1; i >= 0; i--) if (bus.rsp_valid[i]) gi = i;
      if (bus.rsp_ready[gi]) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_idx", 32'(gi), 32'(e.idx));
          check("rsp_p", 32'(bus.rsp_p), 32'(e.p));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          last_rsp_p   = bus.rsp_p;
          last_rsp_err = bus.rsp_err;
        end
      end
    end
    prev_rsp_valid = bus.rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(N); i++) begin
      if (drop[i]) begin
        bus.req_valid[i] = 1'b0;
        drop[i] = 1'b0;
      end
    end
    bus.mul_done = 1'b0;
    if (core_pend) begin
      if (core_cnt <= 1) begin
        bus.mul_done = 1'b1;
        bus.mul_p    = core_prod;
        core_pend    = 1'b0;
      end else begin
        core_cnt--;
      end
    end
    if (bus.mul_start && core_lat != 0) begin
      core_pend = 1'b1;
      core_cnt  = (core_lat < 0) ? int'($urandom_range(5, 1)) : core_lat;
      core_prod = PW'(int'($signed(bus.mul_m)) * int'($signed(bus.mul_r)));
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0 || bus.req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    core_pend = 1'b0;
    drop = '0;
  endtask

  task automatic run_one(input int r, input int m, input int rr, input string tag);
    m_op[r] = MW'(m);
    r_op[r] = Y'(rr);
    bus.req_valid[r] = 1'b1;
    wait_idle(200, tag);
  endtask

  initial begin
    int n;
    int exp_ord [5];
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    bus.mul_done  = 1'b0;
    bus.mul_p     = '0;
    oneshot = '1;
    drop = '0;
    core_lat = 3;
    core_pend = 1'b0;
    prev_rsp_valid = '0;
    last_acc_cyc = 0;
    last_rsp_lat = 0;
    rdy0_cnt = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_op[i] = '0;
      r_op[i] = '0;
    end

    // Reset values, with every request valid to show ready is held low.
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mul_start", 32'(bus.mul_start), 0);
    check("rst_mul_m", 32'(bus.mul_m), 0);
    check("rst_mul_r", 32'(bus.mul_r), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_p", 32'(bus.rsp_p), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request, core done 3 cycles after start.
    rdy0_cnt = 0;
    run_one(0, 4, 6, "single_drain");
    check("single_lat", 32'(last_rsp_lat), 5);
    check("single_rdy_cycles", 32'(rdy0_cnt), 1);
    check("single_p", 32'(last_rsp_p), 24);
    check("single_err", 32'(last_rsp_err), 0);

    // Fairness with all requesters held valid.
    do_reset();
    core_lat = 1;
    oneshot = '0;
    for (int i = 0; i < int'(N); i++) begin
      m_op[i] = MW'(i + 1);
      r_op[i] = Y'(i - 3);
    end
    order.delete();
    bus.req_valid = '1;
    n = 0;
    while (order.size() < 5 && n < 200) begin tick(); n++; end
    bus.req_valid = '0;
    check("fair_count", 32'(order.size()), 5);
    wait_idle(100, "fair_drain");
    exp_ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5 && k < order.size(); k++)
      check("fair_order", 32'(order[k]), 32'(exp_ord[k]));

    order.delete();
    bus.req_valid = 4'b1010;
    n = 0;
    while (order.size() < 3 && n < 200) begin tick(); n++; end
    bus.req_valid = '0;
    check("fair13_count", 32'(order.size()), 3);
    wait_idle(100, "fair13_drain");
    exp_ord = '{1, 3, 1, 0, 0};
    for (int k = 0; k < 3 && k < order.size(); k++)
      check("fair13_order", 32'(order[k]), 32'(exp_ord[k]));
    oneshot = '1;

    // Timeout: core never completes.
    core_lat = 0;
    run_one(2, 3, 3, "tmo_drain");
    check("tmo_lat", 32'(last_rsp_lat), 18);
    check("tmo_err", 32'(last_rsp_err), 1);
    check("tmo_p", 32'(last_rsp_p), 0);
    bus.mul_done = 1'b1;
    bus.mul_p = 8'h5a;
    tick();
    check("tmo_late_busy", 32'(busy), 0);
    check("tmo_late_rsp_valid", 32'(bus.rsp_valid), 0);
    check("tmo_late_rsp_p", 32'(bus.rsp_p), 0);

    // Back-pressure on requester 2 while others wait.
    core_lat = 2;
    order.delete();
    bus.rsp_ready[2] = 1'b0;
    m_op[2] = 5'sd7;
    r_op[2] = -4'sd3;
    bus.req_valid[2] = 1'b1;
    n = 0;
    while (!bus.rsp_valid[2] && n < 100) begin tick(); n++; end
    check("bp_rsp_seen", 32'(bus.rsp_valid[2]), 1);
    m_op[0] = 5'sd1;  r_op[0] = 4'sd2;
    m_op[1] = -5'sd2; r_op[1] = 4'sd5;
    bus.req_valid[1:0] = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rsp_valid", 32'(bus.rsp_valid), 4);
      check("bp_rsp_p", 32'(bus.rsp_p), 32'h0eb);
      check("bp_rsp_err", 32'(bus.rsp_err), 0);
      check("bp_mul_start", 32'(bus.mul_start), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready[2] = 1'b1;
    wait_idle(200, "bp_drain");
    check("bp_order_n", 32'(order.size()), 3);
    if (order.size() == 3) begin
      check("bp_order0", 32'(order[0]), 2);
      check("bp_order1", 32'(order[1]), 0);
      check("bp_order2", 32'(order[2]), 1);
    end

    // Reset while waiting on the core.
    core_lat = 0;
    m_op[0] = 5'sd5;
    r_op[0] = 4'sd5;
    bus.req_valid[0] = 1'b1;
    tick();
    tick();
    tick();
    check("rm_in_wait", 32'(busy && !bus.mul_start), 1);
    rst = 1'b1;
    bus.req_valid[3] = 1'b1;
    tick();
    check("rm_req_ready", 32'(bus.req_ready), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_mul_start", 32'(bus.mul_start), 0);
    check("rm_mul_m", 32'(bus.mul_m), 0);
    check("rm_mul_r", 32'(bus.mul_r), 0);
    check("rm_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rm_rsp_p", 32'(bus.rsp_p), 0);
    check("rm_rsp_err", 32'(bus.rsp_err), 0);
    sb.delete();
    core_pend = 1'b0;
    drop = '0;
    bus.req_valid = '0;
    rst = 1'b0;
    bus.mul_done = 1'b1;
    bus.mul_p = 8'h33;
    tick();
    check("rm_late_busy", 32'(busy), 0);
    check("rm_late_rsp_valid", 32'(bus.rsp_valid), 0);
    core_lat = 2;
    order.delete();
    m_op[1] = 5'sd3;  r_op[1] = -4'sd5;
    m_op[3] = 5'sd2;  r_op[3] = 4'sd2;
    bus.req_valid = 4'b1010;
    wait_idle(200, "rm_drain");
    check("rm_order_n", 32'(order.size()), 2);
    if (order.size() == 2) begin
      check("rm_order0", 32'(order[0]), 1);
      check("rm_order1", 32'(order[1]), 3);
    end

    // Signed operands through the full flow, core done in first WAIT cycle.
    core_lat = 1;
    run_one(3, -5, -7, "sgn0_drain");
    check("sgn_min_lat", 32'(last_rsp_lat), 3);
    check("sgn0_p", 32'(last_rsp_p), 32'h23);
    run_one(0, 10, -6, "sgn1_drain");
    check("sgn1_p", 32'(last_rsp_p), 32'hc4);
    run_one(1, -16, -8, "sgn2_drain");
    check("sgn2_p", 32'(last_rsp_p), 32'h80);
    check("sgn2_err", 32'(last_rsp_err), 0);

    // Random traffic with random core latency and response back-pressure.
    core_lat = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!bus.req_valid[i] && $urandom_range(3, 0) == 0) begin
          m_op[i] = MW'($urandom);
          r_op[i] = Y'($urandom);
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = N'($urandom);
      tick();
    end
    bus.rsp_ready = '1;
    wait_idle(500, "rand_drain");
    check("rand_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Round-robin scheduler that shares one sequential Booth multiplier among N requesters. It sits between the requesting datapaths and the multiplier core. It accepts one operand pair at a time over a valid/ready handshake, pulses the core's start, and waits for done with a timeout guard. It then returns the signed product to the granted requester over a per-requester response handshake.

## Interface
- N, 4: number of requesters (2..8)
- X, 4: multiplicand width minus one; the multiplicand is X+1 bits signed
- Y, 4: multiplier width, Y bits signed
- TIMEOUT, 16: maximum cycles spent in WAIT before an error response
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; at most one bit set
- req_m  in  N*(X+1)  packed multiplicands; requester i uses [i*(X+1) +: X+1]
- req_r  in  N*Y  packed multipliers; requester i uses [i*Y +: Y]
- rsp_valid  out  N  one-hot response valid
- rsp_ready  in  N  per-requester response accept
- rsp_p  out  X+Y  signed product for the current response
- rsp_err  out  1  current response is a timeout error
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_m  out  X+1  operand to the core; held from capture until the next capture
- mul_r  out  Y  operand to the core; held from capture until the next capture
- mul_done  in  1  core completion, one-cycle pulse
- mul_p  in  X+Y  core product, valid with mul_done
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE → START when any req_valid bit is set.
  - START → WAIT unconditionally.
  - WAIT → RESP on mul_done or on timeout.
  - RESP → IDLE when rsp_ready[g] is high.
- Arbitration:
  - Round-robin. Priority starts at pointer ptr and ascends modulo N.
  - Grant g is computed combinationally in IDLE.
  - req_ready[g] = (state==IDLE) && req_valid[g].
  - A transfer occurs when valid and ready are both high at the clock edge. On the transfer, g, req_m slice and req_r slice are captured into mul_m and mul_r.
- START: mul_start=1 for exactly this cycle. The cycle counter is cleared.
- WAIT:
  - mul_done is sampled only in WAIT. A mul_done in any other state is ignored.
  - On mul_done: capture mul_p into rsp_p and set rsp_err=0.
  - If the counter reaches TIMEOUT-1 without mul_done: set rsp_p=0 and rsp_err=1.
  - If mul_done arrives in the same cycle as the timeout, mul_done wins.
- RESP:
  - rsp_valid[g]=1, with rsp_p and rsp_err held stable until rsp_ready[g].
  - rsp_ready on non-granted bits is ignored.
  - On completion, ptr ← (g+1) mod N.
- Arithmetic:
  - Products are two's-complement, full width X+Y, with no saturation.
  - The scheduler never modifies the product.

## Timing
- Reset values:
  - state=IDLE, ptr=0, g=0.
  - req_ready=0 (forced 0 while rst is high).
  - mul_start=0, mul_m=0, mul_r=0.
  - rsp_valid=0, rsp_p=0, rsp_err=0, busy=0.
- Latency:
  - Accept edge t, then mul_start during cycle t+1, then WAIT from t+2.
  - A mul_done in cycle t+2+k gives rsp_valid from t+3+k.
- Minimum period per operation: 4 cycles (done in the first WAIT cycle, rsp_ready already high).
- Back-pressure: while in RESP, no new request is granted.
- Timeout: the error response is valid exactly TIMEOUT cycles after entering WAIT.
- Reset mid-operation: the FSM returns to IDLE on the next edge. The in-flight result is discarded and ptr returns to 0.

## Structure
- Package booth_sched_pkg holds:
  - the state enum (IDLE, START, WAIT, RESP);
  - width helper constants;
  - the counter width function clog2(TIMEOUT).
- Sub-module rr_arbiter (parameter N): combinational grant from the request vector and ptr. Outputs a one-hot grant, a binary index and an any-valid flag.
- The FSM, capture registers and timeout counter live in booth_mul_sched.

## Test plan
- Single request: requester 0, m=4, r=6; the core model returns done 3 cycles after start.
  - req_ready[0] is high for one cycle.
  - rsp_valid[0] asserts with rsp_p=24 and rsp_err=0.
- Fairness: after reset, all four req_valid bits held high.
  - Service order is 0,1,2,3,0.
  - Then, with only requesters 1 and 3 valid, the order is 1,3,1.
- Timeout: TIMEOUT=16, the core model never asserts done.
  - rsp_err=1 and rsp_p=0, valid 16 cycles after WAIT entry.
  - A mul_done injected later, in IDLE, is ignored.
- Back-pressure: rsp_ready[2] held low for 5 cycles.
  - rsp_valid[2], rsp_p and rsp_err remain stable.
  - mul_start stays 0 and no req_ready rises.
- Reset mid-operation: rst asserted in WAIT.
  - On the next cycle, all outputs hold their reset values.
  - A late mul_done is ignored.
  - A following request from requester 1 is served normally.
- Signed values, through the full flow:
  - m=-5, r=-7 gives rsp_p=35.
  - m=10, r=-6 gives rsp_p=-60.
  - m=-16, r=-8 gives rsp_p=128, which wraps to -128 in 8 bits and is not flagged.
